systolic_result_buffer: RTL and testbench

SYSTOLIC_RESULT_BUFFER -- requirements
Module: systolic_result_buffer

---
 rtl/systolic_result_buffer.sv | 120 ++++++++++++
 tb/tb_systolic_result_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_buffer.sv
// rtl/systolic_result_buffer.sv - ping-pong snapshot of a PE result array, drained as a word stream
// Two banks let one capture land while the other bank is still being streamed out.
module systolic_result_buffer #(
  parameter int DIM    = 4,
  parameter int DATA_W = 33,
  localparam int N      = DIM * DIM,
  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cap_en,
  input  logic [N*DATA_W-1:0] c_flat,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [1:0]          level,
  output logic                ovf,
  input  logic                ovf_clr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W + 1)'(N);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state;
  logic [DATA_W-1:0] bank [2][N];
  logic              wr_bank;
  logic              rd_bank;
  logic [ADDR_W-1:0] idx;
  logic              xfer;
  logic              rel;
  logic              accept;
  logic              drop;

  assign xfer   = out_valid && out_ready;
  assign rel    = xfer && (idx == LAST_IDX);
  // A release frees a bank this same cycle, so a capture at level 2 can reuse it.
  assign accept = cap_en && ((level != 2'd2) || rel);
  assign drop   = cap_en && !accept;

  assign out_data = bank[rd_bank][idx];
  assign out_last = out_valid && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < N; k++) begin
          bank[b][k] <= '0;
        end
      end
      wr_bank <= 1'b0;
      level   <= 2'd0;
      ovf     <= 1'b0;
      rd_data <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < N; k++) begin
          bank[wr_bank][k] <= c_flat[k*DATA_W +: DATA_W];
        end
        wr_bank <= ~wr_bank;
      end
      case ({accept, rel})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
      // Overflow wins over a simultaneous clear so a drop is never lost.
      if (drop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if ({1'b0, rd_addr} < N_EXT) begin
        rd_data <= bank[rd_bank][rd_addr];
      end else begin
        rd_data <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      idx       <= '0;
      rd_bank   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (level != 2'd0) begin
            state     <= STREAM;
            out_valid <= 1'b1;
            idx       <= '0;
          end
        end
        STREAM: begin
          if (xfer) begin
            if (idx == LAST_IDX) begin
              idx       <= '0;
              rd_bank   <= ~rd_bank;
              state     <= IDLE;
              out_valid <= 1'b0;
            end else begin
              idx <= idx + ADDR_W'(1);
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_result_buffer.sv
// tb/tb_systolic_result_buffer.sv - scoreboard bench for systolic_result_buffer
module tb_systolic_result_buffer;

  localparam int DIM    = 4;
  localparam int DATA_W = 33;
  localparam int N      = DIM * DIM;
  localparam int ADDR_W = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cap_en = 1'b0;
  logic [N*DATA_W-1:0] c_flat = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic [ADDR_W-1:0]   rd_addr = '0;
  logic [DATA_W-1:0]   rd_data;
  logic [1:0]          level;
  logic                ovf;
  logic                ovf_clr = 1'b0;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  localparam logic [DATA_W-1:0] B1 = 33'h0_0000_0100;
  localparam logic [DATA_W-1:0] B2 = 33'h1_0000_0200;
  localparam logic [DATA_W-1:0] B3 = 33'h0_0000_0300;
  localparam logic [DATA_W-1:0] B4 = 33'h1_FFFF_FF00;
  localparam logic [DATA_W-1:0] B5 = 33'h0_0000_0500;
  localparam logic [DATA_W-1:0] B6 = 33'h0_0000_0600;
  localparam logic [DATA_W-1:0] B7 = 33'h1_0000_0700;
  localparam logic [DATA_W-1:0] B8 = 33'h0_0000_0800;
  localparam logic [DATA_W-1:0] B9 = 33'h0_0000_0900;

  systolic_result_buffer #(.DIM(DIM), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .c_flat(c_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .rd_addr(rd_addr), .rd_data(rd_data),
    .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [N*DATA_W-1:0] make_flat(input logic [DATA_W-1:0] base);
    logic [N*DATA_W-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++) f[k*DATA_W +: DATA_W] = base + DATA_W'(k + 1);
    return f;
  endfunction

  task automatic push_bank(input logic [DATA_W-1:0] base);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.data = base + DATA_W'(k + 1);
      e.last = (k == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; cap_en = 1'b0; ovf_clr = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input bit toggle, input int bound);
    int n;
    n = 0;
    out_ready = 1'b1;
    do begin
      tick();
      n++;
      if (toggle) out_ready = ~out_ready;
    end while (exp_q.size() != 0 && n < bound);
    out_ready = 1'b1;
    chk("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every presented word must match the scoreboard head; pop only on transfer.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {31'd0, out_data}, 64'h0);
      end else begin
        chk("out_data", {31'd0, out_data}, {31'd0, exp_q[0].data});
        chk("out_last", {63'd0, out_last}, {63'd0, exp_q[0].last});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset_dut();
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_last", {63'd0, out_last}, 64'd0);
    chk("rst_level", {62'd0, level}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    chk("rst_rd_data", {31'd0, rd_data}, 64'd0);

    // Single capture, latency, debug reads during the stream
    tick();
    c_flat = make_flat('0); cap_en = 1'b1; out_ready = 1'b1;
    push_bank('0);
    tick();
    cap_en = 1'b0; rd_addr = 4'd5;
    @(negedge clk);
    chk("lat_level1", {62'd0, level}, 64'd1);
    chk("lat_not_yet_valid", {63'd0, out_valid}, 64'd0);
    tick();
    rd_addr = 4'd15;
    @(negedge clk);
    chk("first_valid", {63'd0, out_valid}, 64'd1);
    chk("rd_addr5", {31'd0, rd_data}, 64'd6);
    tick();
    @(negedge clk);
    chk("rd_addr15", {31'd0, rd_data}, 64'd16);
    for (int i = 0; i < 14; i++) begin
      tick();
      @(negedge clk);
      chk("consecutive_valid", {63'd0, out_valid}, 64'd1);
    end
    tick();
    @(negedge clk);
    chk("s1_idle_after", {63'd0, out_valid}, 64'd0);
    chk("s1_level0", {62'd0, level}, 64'd0);
    chk("s1_queue_empty", 64'(exp_q.size()), 64'd0);

    // Overflow with stalled output, ovf_clr behaviour
    reset_dut();
    tick();
    c_flat = make_flat(B1); cap_en = 1'b1; push_bank(B1);
    tick();
    c_flat = make_flat(B2); push_bank(B2);
    tick();
    c_flat = make_flat(B3);
    @(negedge clk);
    chk("two_caps_level", {62'd0, level}, 64'd2);
    chk("two_caps_ovf", {63'd0, ovf}, 64'd0);
    tick();
    cap_en = 1'b0;
    @(negedge clk);
    chk("drop_level", {62'd0, level}, 64'd2);
    chk("drop_ovf", {63'd0, ovf}, 64'd1);
    chk("hold_valid", {63'd0, out_valid}, 64'd1);
    chk("hold_data", {31'd0, out_data}, {31'd0, B1 + 33'd1});
    tick(); ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", {63'd0, ovf}, 64'd0);
    tick(); ovf_clr = 1'b1; cap_en = 1'b1; c_flat = make_flat(B3);
    tick(); ovf_clr = 1'b0; cap_en = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", {63'd0, ovf}, 64'd1);
    chk("ovf_set_level", {62'd0, level}, 64'd2);
    tick(); ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;

    // Capture on the release cycle at level 2
    tick(); out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_last) found = 1'b1;
    end
    chk("last_seen", {63'd0, found}, 64'd1);
    cap_en = 1'b1; c_flat = make_flat(B4); push_bank(B4);
    tick();
    cap_en = 1'b0;
    @(negedge clk);
    chk("swap_level", {62'd0, level}, 64'd2);
    chk("swap_ovf", {63'd0, ovf}, 64'd0);
    chk("gap_idle", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("gap_resume", {63'd0, out_valid}, 64'd1);
    drain(1'b0, 80);
    @(negedge clk);
    chk("s3_level0", {62'd0, level}, 64'd0);
    chk("s3_ovf", {63'd0, ovf}, 64'd0);

    // Alternating out_ready over one bank
    reset_dut();
    tick();
    c_flat = make_flat(B5); cap_en = 1'b1; push_bank(B5);
    tick();
    cap_en = 1'b0;
    drain(1'b1, 100);
    @(negedge clk);
    chk("s4_level0", {62'd0, level}, 64'd0);

    // Reset mid-drain
    reset_dut();
    rd_addr = 4'd3;
    tick();
    c_flat = make_flat(B6); cap_en = 1'b1; push_bank(B6);
    tick();
    c_flat = make_flat(B7); push_bank(B7);
    tick();
    c_flat = make_flat(B8);
    tick();
    cap_en = 1'b0;
    @(negedge clk);
    chk("pre_rst_ovf", {63'd0, ovf}, 64'd1);
    chk("pre_rst_rd_data", {31'd0, rd_data}, {31'd0, B6 + 33'd4});
    tick(); out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_data == B6 + 33'd7) found = 1'b1;
    end
    chk("word7_seen", {63'd0, found}, 64'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_valid", {63'd0, out_valid}, 64'd0);
    chk("abort_level", {62'd0, level}, 64'd0);
    chk("abort_ovf", {63'd0, ovf}, 64'd0);
    chk("abort_rd_data", {31'd0, rd_data}, 64'd0);
    tick();
    c_flat = make_flat(B9); cap_en = 1'b1; push_bank(B9);
    tick();
    cap_en = 1'b0;
    drain(1'b0, 60);
    @(negedge clk);
    chk("s5_level0", {62'd0, level}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
